// File: rtl/gups_pkg.sv
// Shared types and the LFSR step used by the GUPS read-modify-write engine.
package gups_pkg;

    localparam logic [63:0] LFSR_POLY = 64'h7;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic {MODE_INC, MODE_XOR} mode_t;

    function automatic logic [63:0] lfsr_step(input logic [63:0] cur);
        return {cur[62:0], 1'b0} ^ (cur[63] ? LFSR_POLY : 64'h0);
    endfunction

endpackage

// File: rtl/gups_tag_fifo.sv
// Synchronous FIFO holding {address, lfsr} tags for reads awaiting their response.
module gups_tag_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/gups_engine.sv
// Random-access RMW engine: LFSR addresses, up to DEPTH outstanding reads, one-entry write register.
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads until num_updates have been issued
// DRAIN | all reads issued, waiting for the remaining writes
// DONE  | one-cycle completion pulse
module gups_engine
    import gups_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [63:0]       seed,
    input  logic [ADDR_W-1:0] range_mask,
    input  logic [CNT_W-1:0]  num_updates,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  update_count,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    output logic              rd_rsp_ready,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam int TAG_W = ADDR_W + 64;

    state_t            state, state_nx;
    logic [63:0]       lfsr;
    logic [63:0]       lfsr_nx;
    logic [ADDR_W-1:0] mask_r;
    logic [CNT_W-1:0]  num_r;
    logic [CNT_W-1:0]  issued;
    mode_t             mode_r;
    logic              fifo_full, fifo_empty;
    logic [TAG_W-1:0]  fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [63:0]       head_lfsr;
    logic              rd_fire, rsp_fire, wr_fire, start_ok;

    assign lfsr_nx   = lfsr_step(lfsr);
    assign head_addr = fifo_head[TAG_W-1:64];
    assign head_lfsr = fifo_head[63:0];

    assign rd_req_valid = (state == RUN) && (issued < num_r) && !fifo_full;
    assign rd_req_addr  = rd_req_valid ? (lfsr_nx[ADDR_W-1:0] & mask_r) : '0;
    assign rd_rsp_ready = !fifo_empty && (!wr_valid || wr_ready);
    assign rd_fire      = rd_req_valid && rd_req_ready;
    assign rsp_fire     = rd_rsp_valid && rd_rsp_ready;
    assign wr_fire      = wr_valid && wr_ready;
    assign start_ok     = (state == IDLE) && start;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    gups_tag_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_fire),
        .push_data ({rd_req_addr, lfsr_nx}),
        .pop       (rsp_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_updates == '0) ? DONE : RUN;
            RUN:     if (issued == num_r) state_nx = DRAIN;
            DRAIN:   if (update_count == num_r) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr         <= '0;
            mask_r       <= '0;
            num_r        <= '0;
            mode_r       <= MODE_INC;
            issued       <= '0;
            update_count <= '0;
            wr_valid     <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            if (start_ok) begin
                lfsr         <= (seed == 64'h0) ? 64'h1 : seed;
                mask_r       <= range_mask;
                num_r        <= num_updates;
                mode_r       <= mode_t'(mode);
                issued       <= '0;
                update_count <= '0;
            end
            if (rd_fire) begin
                lfsr   <= lfsr_nx;
                issued <= issued + CNT_W'(1);
            end
            // A refill may land in the same cycle the previous write is accepted.
            if (rsp_fire) begin
                wr_valid <= 1'b1;
                wr_addr  <= head_addr;
                wr_data  <= (mode_r == MODE_XOR) ? (rd_rsp_data ^ head_lfsr[DATA_W-1:0])
                                                 : (rd_rsp_data + DATA_W'(1));
            end else if (wr_fire) begin
                wr_valid <= 1'b0;
            end
            if (wr_fire) update_count <= update_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gups_engine.sv
// Self-checking bench for gups_engine: directed table, corner sequences and randomized runs.
module tb_gups_engine;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [63:0]       seed = '0;
    logic [ADDR_W-1:0] range_mask = '0;
    logic [CNT_W-1:0]  num_updates = '0;
    logic              mode = 1'b0;
    logic              busy, done;
    logic [CNT_W-1:0]  update_count;
    logic              rd_req_valid;
    logic              rd_req_ready = 1'b0;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid = 1'b0;
    logic              rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_data = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    gups_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed), .range_mask(range_mask),
        .num_updates(num_updates), .mode(mode), .busy(busy), .done(done),
        .update_count(update_count), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data(rd_rsp_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Memory-side and sequencing knobs
    int          rdq_pct = 100, wr_pct = 100, rsp_pct = 100;
    bit          rsp_en = 1'b1, wr_hold = 1'b0, rand_data = 1'b0;
    bit          start_knob = 1'b0, rst_knob = 1'b1, rsp_pending = 1'b0;
    logic [63:0] const_data = '0;
    int          pend_n = 0;
    int          cyc = 0;

    // Reference model
    typedef struct { logic [ADDR_W-1:0] addr; logic [63:0] val; } tag_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    tag_t              m_q[$];
    wr_t               m_wq[$];
    bit                m_busy = 1'b0;
    logic [63:0]       m_lfsr = '0;
    logic [ADDR_W-1:0] m_mask = '0;
    int                m_num = 0, m_issued = 0, m_wrs = 0;
    bit                m_mode = 1'b0;

    // Per-run statistics
    int                rd_n = 0, wr_n = 0, done_n = 0, busy_n = 0;
    int                first_wr_cyc = -1, last_wr_cyc = -1;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [DATA_W-1:0] last_wdata = '0;

    typedef struct {
        logic [63:0]       seed;
        logic [ADDR_W-1:0] mask;
        int                num;
        bit                mode;
        logic [63:0]       data;
        logic [ADDR_W-1:0] first_addr;
        logic [DATA_W-1:0] last_wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiply by two modulo 2^64, folding the carried-out bit back in as 0x7.
    function automatic logic [63:0] model_step(input logic [63:0] x);
        logic [63:0] y;
        y = x * 64'd2;
        if (x >= 64'h8000_0000_0000_0000) y = y ^ 64'd7;
        return y;
    endfunction

    task automatic cycle();
        tag_t t;
        wr_t  w;
        @(negedge clk);
        cyc++;
        reset_n      = !rst_knob;
        start        = start_knob;
        start_knob   = 1'b0;
        rd_req_ready = ($urandom_range(99) < rdq_pct);
        wr_ready     = !wr_hold && ($urandom_range(99) < wr_pct);
        if (!rsp_pending) begin
            if (rsp_en && pend_n > 0 && $urandom_range(99) < rsp_pct) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = rand_data ? {$urandom, $urandom} : const_data;
                rsp_pending  = 1'b1;
            end else begin
                rd_rsp_valid = 1'b0;
            end
        end
        #1;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_wrs  = 0;
            m_q.delete();
            m_wq.delete();
            return;
        end
        check("busy", busy, m_busy);
        check("update_count", update_count, m_wrs);
        check("rd_req_valid", rd_req_valid, m_busy && m_issued < m_num && m_q.size() < DEPTH);
        check("wr_valid", wr_valid, m_wq.size() > 0);
        check("rd_rsp_ready", rd_rsp_ready, m_q.size() > 0 && (m_wq.size() == 0 || wr_ready));
        if (start && !m_busy) begin
            m_busy = 1'b1;
            m_lfsr = (seed == 64'h0) ? 64'h1 : seed;
            m_mask = range_mask;
            m_num = int'(num_updates);
            m_mode = mode;
            m_issued = 0; m_wrs = 0;
            rd_n = 0; wr_n = 0; done_n = 0; busy_n = 0;
            first_wr_cyc = -1; last_wr_cyc = -1;
        end
        if (rd_req_valid && !rd_req_ready)
            check("rd_hold_addr", rd_req_addr, model_step(m_lfsr)[ADDR_W-1:0] & m_mask);
        if (rd_req_valid && rd_req_ready) begin
            m_lfsr = model_step(m_lfsr);
            check("rd_addr", rd_req_addr, m_lfsr[ADDR_W-1:0] & m_mask);
            t.addr = m_lfsr[ADDR_W-1:0] & m_mask;
            t.val  = m_lfsr;
            m_q.push_back(t);
            if (rd_n == 0) first_addr = rd_req_addr;
            m_issued++; rd_n++; pend_n++;
        end
        if (wr_valid && !wr_ready && m_wq.size() > 0) begin
            check("wr_hold_addr", wr_addr, m_wq[0].addr);
            check("wr_hold_data", wr_data, m_wq[0].data);
        end
        if (wr_valid && wr_ready) begin
            check("wr_expected", m_wq.size() > 0, 1);
            if (m_wq.size() > 0) begin
                w = m_wq.pop_front();
                check("wr_addr", wr_addr, w.addr);
                check("wr_data", wr_data, w.data);
            end
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            last_wdata  = wr_data;
            m_wrs++; wr_n++;
        end
        if (rd_rsp_valid && rd_rsp_ready) begin
            rsp_pending = 1'b0;
            pend_n--;
            check("rsp_has_outstanding", m_q.size() > 0, 1);
            if (m_q.size() > 0) begin
                t = m_q.pop_front();
                w.addr = t.addr;
                w.data = m_mode ? (rd_rsp_data ^ t.val[DATA_W-1:0]) : (rd_rsp_data + DATA_W'(1));
                m_wq.push_back(w);
            end
        end
        if (busy) busy_n++;
        if (done) begin
            done_n++;
            check("done_all_written", m_wrs, m_num);
            m_busy = 1'b0;
        end
    endtask

    task automatic start_run(input logic [63:0] s, input logic [ADDR_W-1:0] m, input int n, input bit md);
        seed = s; range_mask = m; num_updates = CNT_W'(n); mode = md;
        start_knob = 1'b1;
        cycle();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_n == 0 && n < budget) begin
            cycle();
            n++;
        end
        check("done_within_budget", done_n > 0, 1);
        repeat (3) cycle();
        check("single_done_pulse", done_n, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_update_count", update_count, 0);
        check("rst_rd_req_valid", rd_req_valid, 0);
        check("rst_rd_rsp_ready", rd_rsp_ready, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_req_addr", rd_req_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required summary before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{64'd1, 32'hFF, 8, 1'b0, 64'd0, 32'h2, 64'd1};
        vecs[1] = '{64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 1, 1'b1, 64'hFF, 32'h7, 64'hF8};
        vecs[2] = '{64'd0, 32'hF, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h2, 64'h0};
        vecs[3] = '{64'd3, 32'hFFF, 5, 1'b1, 64'd0, 32'h6, 64'h60};
        vecs[4] = '{64'h4000_0000_0000_0001, 32'hFFFF_FFFF, 2, 1'b1, 64'd0, 32'h2, 64'h3};

        repeat (3) cycle();
        rst_knob = 1'b0;
        cycle();
        check_reset_outputs();

        // Directed table, all ready inputs high
        for (int i = 0; i < 5; i++) begin
            const_data = vecs[i].data;
            start_run(vecs[i].seed, vecs[i].mask, vecs[i].num, vecs[i].mode);
            wait_done(200);
            check("tbl_first_addr", first_addr, vecs[i].first_addr);
            check("tbl_last_wdata", last_wdata, vecs[i].last_wdata);
            check("tbl_update_count", update_count, vecs[i].num);
            check("tbl_reads", rd_n, vecs[i].num);
            check("tbl_write_streak", last_wr_cyc - first_wr_cyc, vecs[i].num - 1);
        end

        // Responses withheld: FIFO fills at DEPTH, a start while busy is ignored
        rsp_en = 1'b0;
        const_data = 64'h1234;
        start_run(64'h0123_4567_89AB_CDEF, 32'hFFFF, 16, 1'b0);
        repeat (10) cycle();
        seed = 64'h5555;
        start_knob = 1'b1;
        repeat (10) cycle();
        check("withheld_reads", rd_n, DEPTH);
        check("withheld_rd_valid", rd_req_valid, 0);
        rsp_en = 1'b1;
        wait_done(300);
        check("withheld_final_count", update_count, 16);

        // Write backpressure with wrap-around increment
        const_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_hold = 1'b1;
        start_run(64'h0000_0000_0000_0ABC, 32'hFFFF_FFFF, 2, 1'b0);
        for (int i = 0; i < 20 && !wr_valid; i++) cycle();
        check("hold_wr_valid_seen", wr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_wr_valid", wr_valid, 1);
            check("hold_rsp_ready", rd_rsp_ready, 0);
            check("hold_wr_data_wrap", wr_data, 0);
        end
        wr_hold = 1'b0;
        wait_done(100);
        check("hold_final_count", update_count, 2);

        // Zero-length run
        start_run(64'd9, 32'hFF, 0, 1'b0);
        repeat (6) cycle();
        check("zero_busy_cycles", busy_n, 1);
        check("zero_done_pulses", done_n, 1);
        check("zero_reads", rd_n, 0);
        check("zero_update_count", update_count, 0);

        // Reset with reads in flight; stale responses must be ignored
        rsp_en = 1'b0;
        start_run(64'hDEAD_BEEF_0000_0001, 32'hFFFF_FFFF, 20, 1'b1);
        for (int i = 0; i < 20 && rd_n < 4; i++) cycle();
        check("inflight_reads", rd_n, 4);
        rst_knob = 1'b1;
        cycle();
        rst_knob = 1'b0;
        rsp_en = 1'b1;
        cycle();
        check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stale_rsp_ready", rd_rsp_ready, 0);
            check("stale_wr_valid", wr_valid, 0);
        end
        pend_n = 0;
        rsp_pending = 1'b0;
        const_data = 64'd0;
        cycle();
        start_run(64'd1, 32'hFF, 4, 1'b0);
        wait_done(100);
        check("post_reset_first_addr", first_addr, 32'h2);
        check("post_reset_count", update_count, 4);

        // Randomized runs with random ready/valid timing and data
        rand_data = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int n;
            rdq_pct = $urandom_range(100, 50);
            wr_pct  = $urandom_range(100, 50);
            rsp_pct = $urandom_range(100, 40);
            n = $urandom_range(40, 1);
            start_run({$urandom, $urandom}, $urandom_range(1) ? 32'h3F : 32'hFFFF_FFFF,
                      n, 1'($urandom_range(1)));
            wait_done(2000);
            check("rand_update_count", update_count, n);
            check("rand_writes", wr_n, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
